// File: rtl/xadc_pkg.sv
// Shared definitions for the multi-channel XADC sampler.
//   RES_W      : width of one XADC conversion result
//   CH_W       : width of the channel index carried with each output sample
//   CHAN_W     : width of the XADC channel number
//   DRP_AW     : width of the DRP address
//   xadc_state_t : sequencing FSM states
//   drp_status_addr() : DRP address of the status register for an XADC channel
package xadc_pkg;

    localparam int unsigned RES_W  = 12;
    localparam int unsigned CH_W   = 4;
    localparam int unsigned CHAN_W = 5;
    localparam int unsigned DRP_AW = 7;

    // Status register of VAUX0; auxiliary status registers follow contiguously.
    localparam logic [DRP_AW-1:0] DRP_ADDR_VAUX0 = 7'h10;
    localparam logic [CHAN_W-1:0] XADC_CH_VAUX0  = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACCUM,
        EMIT
    } xadc_state_t;

    // Status registers are laid out at the channel number itself, so the
    // VAUX offset and the channel offset cancel.
    function automatic logic [DRP_AW-1:0] drp_status_addr(input logic [CHAN_W-1:0] ch);
        return DRP_ADDR_VAUX0 + {2'b00, ch - XADC_CH_VAUX0};
    endfunction

endpackage

// File: rtl/xadc_multi_sampler_if.sv
// DRP and sample-stream bundle between the XADC wrapper, the sampler and the
// data consumer.
//   eoc_i, channel_i      : end-of-conversion strobe and its channel number
//   den_o, daddr_o        : DRP read request
//   drdy_i, do_i          : DRP read response
//   sample_o, sample_ch_o : averaged result and channel index
//   sample_valid_o        : one-cycle strobe qualifying the sample
// Modports: master = sampler side, slave = XADC wrapper / consumer side.
interface xadc_multi_sampler_if;
    import xadc_pkg::*;

    logic                eoc_i;
    logic [CHAN_W-1:0]   channel_i;
    logic                den_o;
    logic [DRP_AW-1:0]   daddr_o;
    logic                drdy_i;
    logic [15:0]         do_i;
    logic [RES_W-1:0]    sample_o;
    logic [CH_W-1:0]     sample_ch_o;
    logic                sample_valid_o;

    modport master (
        input  eoc_i, channel_i, drdy_i, do_i,
        output den_o, daddr_o, sample_o, sample_ch_o, sample_valid_o
    );

    modport slave (
        output eoc_i, channel_i, drdy_i, do_i,
        input  den_o, daddr_o, sample_o, sample_ch_o, sample_valid_o
    );

endinterface

// File: rtl/xadc_chan_avg.sv
// Per-channel accumulator and sample counter array.
//   clk_i, reset_i : clock, synchronous active-high reset
//   idx_i          : channel slot addressed this cycle
//   sample_i       : new conversion result
//   add_i          : add sample_i into slot idx_i and advance its counter
//   clear_i        : zero the accumulator of slot idx_i
//   sum_o          : accumulator of slot idx_i plus sample_i
//   done_o         : slot idx_i holds 2^AVG_LOG2-1 samples, so add_i completes a set
module xadc_chan_avg
    import xadc_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned AVG_LOG2 = 2,
    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned ACC_W   = RES_W + AVG_LOG2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [RES_W-1:0] sample_i,
    input  logic             add_i,
    input  logic             clear_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             done_o
);

    // A zero-width counter is not legal; with no averaging the single bit
    // stays at zero because every add completes a set.
    localparam int unsigned      CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    assign sum_o  = acc_q[idx_i] + ACC_W'(sample_i);
    assign done_o = (cnt_q[idx_i] == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (add_i) begin
            acc_q[idx_i] <= sum_o;
            cnt_q[idx_i] <= done_o ? '0 : cnt_q[idx_i] + CNT_W'(1);
        end else if (clear_i) begin
            acc_q[idx_i] <= '0;
        end
    end

endmodule

// File: rtl/xadc_multi_sampler.sv
// Multi-channel XADC DRP sampler: on each end-of-conversion for a serviced
// auxiliary channel, reads the channel's status register over DRP, averages
// 2^AVG_LOG2 results per channel and emits a tagged sample.
//   CLK100MHZ  : block clock, same as the XADC dclk_in
//   reset_i    : synchronous active-high reset
//   bus        : xadc_multi_sampler_if.master (eoc/channel in, DRP, sample stream)
//   busy_o     : FSM not idle
//   timeout_o  : sticky, a DRP read got no drdy within TIMEOUT cycles
//   overrun_o  : sticky, eoc arrived while busy and was dropped
//   thresh_i, alarm_o : present only with XADC_SAMPLER_THRESH_EN defined;
//                       alarm_o[ch] latches when an emitted sample exceeds thresh_i
module xadc_multi_sampler
    import xadc_pkg::*;
#(
    parameter int unsigned        NUM_CH   = 4,
    parameter logic [CHAN_W-1:0]  FIRST_CH = 5'd22,
    parameter int unsigned        AVG_LOG2 = 2,
    parameter int unsigned        TIMEOUT  = 64
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset_i,
    xadc_multi_sampler_if.master  bus,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  overrun_o
`ifdef XADC_SAMPLER_THRESH_EN
   ,input  logic [RES_W-1:0]      thresh_i,
    output logic [NUM_CH-1:0]     alarm_o
`endif
);

    localparam int unsigned     IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned     ACC_W   = RES_W + AVG_LOG2;
    localparam int unsigned     TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    // One extra bit so FIRST_CH + NUM_CH past channel 31 still compares correctly.
    localparam logic [5:0]      FIRST_X = {1'b0, FIRST_CH};
    localparam logic [5:0]      NUM_X   = 6'(NUM_CH);

    xadc_state_t       state_q;
    logic [CH_W-1:0]   idx_q;
    logic [RES_W-1:0]  data_q;
    logic [TO_W-1:0]   wait_cnt_q;
    logic              den_q;
    logic [DRP_AW-1:0] daddr_q;
    logic [RES_W-1:0]  sample_q;
    logic [CH_W-1:0]   sample_ch_q;
    logic              valid_q;
    logic              busy_q;
    logic              timeout_q;
    logic              overrun_q;

    logic [5:0]        ch_off;
    logic              in_range;
    logic [ACC_W-1:0]  acc_sum;
    logic              acc_done;
    logic              unused_do;

    assign ch_off   = {1'b0, bus.channel_i} - FIRST_X;
    assign in_range = ({1'b0, bus.channel_i} >= FIRST_X) && (ch_off < NUM_X);
    // The low nibble of the status register carries no result bits.
    assign unused_do = ^bus.do_i[3:0];

    xadc_chan_avg #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_chan_avg (
        .clk_i    (CLK100MHZ),
        .reset_i  (reset_i),
        .idx_i    (idx_q[IDX_W-1:0]),
        .sample_i (data_q),
        .add_i    (state_q == ACCUM),
        .clear_i  (state_q == EMIT),
        .sum_o    (acc_sum),
        .done_o   (acc_done)
    );

`ifdef XADC_SAMPLER_THRESH_EN
    logic [NUM_CH-1:0] alarm_q;
    assign alarm_o = alarm_q;
`endif

    // Outputs are registered alongside the state, so each strobe is high for
    // exactly the cycle its state is occupied.
    always_ff @(posedge CLK100MHZ) begin
        if (reset_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            wait_cnt_q  <= '0;
            den_q       <= 1'b0;
            daddr_q     <= '0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef XADC_SAMPLER_THRESH_EN
            alarm_q     <= '0;
`endif
        end else begin
            den_q   <= 1'b0;
            valid_q <= 1'b0;
            if (bus.eoc_i && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.eoc_i && in_range) begin
                        idx_q   <= ch_off[CH_W-1:0];
                        daddr_q <= drp_status_addr(bus.channel_i);
                        den_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (bus.drdy_i) begin
                        data_q  <= bus.do_i[15:4];
                        state_q <= ACCUM;
                    end else if (wait_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TO_W'(1);
                    end
                end
                ACCUM: begin
                    if (acc_done) begin
                        sample_q    <= RES_W'(acc_sum >> AVG_LOG2);
                        sample_ch_q <= idx_q;
                        valid_q     <= 1'b1;
                        state_q     <= EMIT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                EMIT: begin
`ifdef XADC_SAMPLER_THRESH_EN
                    if (sample_q > thresh_i) begin
                        alarm_q[idx_q[IDX_W-1:0]] <= 1'b1;
                    end
`endif
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.den_o          = den_q;
    assign bus.daddr_o        = daddr_q;
    assign bus.sample_o       = sample_q;
    assign bus.sample_ch_o    = sample_ch_q;
    assign bus.sample_valid_o = valid_q;
    assign busy_o             = busy_q;
    assign timeout_o          = timeout_q;
    assign overrun_o          = overrun_q;

endmodule

// File: tb/tb_xadc_multi_sampler.sv
// Directed bench for xadc_multi_sampler: one instance without averaging
// (u_dut0) and one averaging 4 samples (u_dut2), fed the same stimulus.
module tb_xadc_multi_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc;
    logic [4:0]  channel;
    logic        drdy;
    logic [15:0] do_data;
    logic        busy0, timeout0, overrun0;
    logic        busy2, timeout2, overrun2;
`ifdef XADC_SAMPLER_THRESH_EN
    logic [11:0] thresh = 12'h800;
    logic [3:0]  alarm0, alarm2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int nval0   = 0;
    int nval2   = 0;
    int nden0   = 0;

    xadc_multi_sampler_if if0 ();
    xadc_multi_sampler_if if2 ();

    assign if0.eoc_i     = eoc;
    assign if0.channel_i = channel;
    assign if0.drdy_i    = drdy;
    assign if0.do_i      = do_data;
    assign if2.eoc_i     = eoc;
    assign if2.channel_i = channel;
    assign if2.drdy_i    = drdy;
    assign if2.do_i      = do_data;

    xadc_multi_sampler #(
        .NUM_CH(4), .FIRST_CH(5'd22), .AVG_LOG2(0), .TIMEOUT(64)
    ) u_dut0 (
        .CLK100MHZ (clk),
        .reset_i   (rst),
        .bus       (if0),
        .busy_o    (busy0),
        .timeout_o (timeout0),
        .overrun_o (overrun0)
`ifdef XADC_SAMPLER_THRESH_EN
       ,.thresh_i  (thresh),
        .alarm_o   (alarm0)
`endif
    );

    xadc_multi_sampler #(
        .NUM_CH(4), .FIRST_CH(5'd22), .AVG_LOG2(2), .TIMEOUT(64)
    ) u_dut2 (
        .CLK100MHZ (clk),
        .reset_i   (rst),
        .bus       (if2),
        .busy_o    (busy2),
        .timeout_o (timeout2),
        .overrun_o (overrun2)
`ifdef XADC_SAMPLER_THRESH_EN
       ,.thresh_i  (thresh),
        .alarm_o   (alarm2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if0.sample_valid_o) nval0 <= nval0 + 1;
        if (if2.sample_valid_o) nval2 <= nval2 + 1;
        if (if0.den_o)          nden0 <= nden0 + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1; eoc = 1'b0; drdy = 1'b0; channel = '0; do_data = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    // Full read: eoc, den, drdy one cycle into WAIT, then settle back to IDLE.
    task automatic do_read(input logic [4:0] ch, input logic [11:0] val);
        eoc = 1'b1; channel = ch; tick; eoc = 1'b0;
        tick;
        drdy = 1'b1; do_data = {val, 4'h0}; tick; drdy = 1'b0; do_data = '0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        reset_dut;
        n_tests++;
        if ({if0.den_o, if0.daddr_o, if0.sample_o, if0.sample_ch_o, if0.sample_valid_o,
             busy0, timeout0, overrun0} !== 32'h0) begin
            n_fail++; $display("FAIL reset_dut0: got den=%b addr=%h smp=%h busy=%b to=%b ov=%b want all 0",
                if0.den_o, if0.daddr_o, if0.sample_o, busy0, timeout0, overrun0);
        end
        n_tests++;
        if ({if2.den_o, if2.daddr_o, if2.sample_o, if2.sample_ch_o, if2.sample_valid_o,
             busy2, timeout2, overrun2} !== 32'h0) begin
            n_fail++; $display("FAIL reset_dut2: got den=%b addr=%h smp=%h busy=%b want all 0",
                if2.den_o, if2.daddr_o, if2.sample_o, busy2);
        end
    endtask

    task automatic test_single_read;
        int d0;
        reset_dut;
        d0 = nden0;
        eoc = 1'b1; channel = 5'd22; tick; eoc = 1'b0;
        n_tests++;
        if (if0.den_o !== 1'b1) begin n_fail++; $display("FAIL t1_den: got %b want 1", if0.den_o); end
        n_tests++;
        if (if0.daddr_o !== 7'h16) begin n_fail++; $display("FAIL t1_daddr: got %h want 16", if0.daddr_o); end
        n_tests++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy0); end
        tick;
        n_tests++;
        if (if0.den_o !== 1'b0) begin n_fail++; $display("FAIL t1_den_one_cycle: got %b want 0", if0.den_o); end
        tick; tick;
        drdy = 1'b1; do_data = 16'hABC0; tick; drdy = 1'b0; do_data = '0;
        n_tests++;
        if (if0.sample_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL t1_early_valid: got %b want 0", if0.sample_valid_o);
        end
        tick;
        n_tests++;
        if ({if0.sample_valid_o, if0.sample_o, if0.sample_ch_o} !== {1'b1, 12'hABC, 4'd0}) begin
            n_fail++; $display("FAIL t1_sample: got v=%b s=%h ch=%0d want v=1 s=abc ch=0",
                if0.sample_valid_o, if0.sample_o, if0.sample_ch_o);
        end
        tick;
        n_tests++;
        if ({if0.sample_valid_o, busy0, if0.sample_o} !== {1'b0, 1'b0, 12'hABC}) begin
            n_fail++; $display("FAIL t1_after: got v=%b busy=%b s=%h want v=0 busy=0 s=abc",
                if0.sample_valid_o, busy0, if0.sample_o);
        end
        n_tests++;
        if (nden0 - d0 !== 1) begin n_fail++; $display("FAIL t1_den_count: got %0d want 1", nden0 - d0); end
    endtask

    task automatic test_average;
        logic [4:0]  chs  [8] = '{5'd23, 5'd22, 5'd23, 5'd22, 5'd23, 5'd23, 5'd22, 5'd22};
        logic [11:0] vals [8] = '{12'd100, 12'd7, 12'd101, 12'd9, 12'd102, 12'd105, 12'd11, 12'd13};
        int v0, v2;
        reset_dut;
        v0 = nval0; v2 = nval2;
        for (int i = 0; i < 5; i++) do_read(chs[i], vals[i]);
        n_tests++;
        if (nval2 - v2 !== 0) begin n_fail++; $display("FAIL t2_early_emit: got %0d want 0", nval2 - v2); end
        do_read(chs[5], vals[5]);
        n_tests++;
        if ({nval2 - v2, if2.sample_o, if2.sample_ch_o} !== {32'd1, 12'd102, 4'd1}) begin
            n_fail++; $display("FAIL t2_avg_ch23: got n=%0d s=%0d ch=%0d want n=1 s=102 ch=1",
                nval2 - v2, if2.sample_o, if2.sample_ch_o);
        end
        do_read(chs[6], vals[6]);
        do_read(chs[7], vals[7]);
        n_tests++;
        if ({nval2 - v2, if2.sample_o, if2.sample_ch_o} !== {32'd2, 12'd10, 4'd0}) begin
            n_fail++; $display("FAIL t2_avg_ch22: got n=%0d s=%0d ch=%0d want n=2 s=10 ch=0",
                nval2 - v2, if2.sample_o, if2.sample_ch_o);
        end
        n_tests++;
        if ({nval0 - v0, if0.sample_o} !== {32'd8, 12'd13}) begin
            n_fail++; $display("FAIL t2_noavg: got n=%0d s=%0d want n=8 s=13", nval0 - v0, if0.sample_o);
        end
    endtask

    task automatic test_out_of_range;
        logic [4:0] chs [3] = '{5'd16, 5'd21, 5'd26};
        int d0, v0, v2;
        reset_dut;
        d0 = nden0; v0 = nval0; v2 = nval2;
        for (int i = 0; i < 3; i++) begin
            eoc = 1'b1; channel = chs[i]; tick; eoc = 1'b0;
            n_tests++;
            if ({if0.den_o, busy0, busy2} !== 3'b000) begin
                n_fail++; $display("FAIL t3_ignore_ch%0d: got den=%b busy0=%b busy2=%b want 000",
                    chs[i], if0.den_o, busy0, busy2);
            end
            tick; tick;
        end
        n_tests++;
        if ((nden0 - d0) + (nval0 - v0) + (nval2 - v2) !== 0) begin
            n_fail++; $display("FAIL t3_activity: got den=%0d val=%0d/%0d want 0",
                nden0 - d0, nval0 - v0, nval2 - v2);
        end
    endtask

    task automatic test_timeout;
        int v2;
        reset_dut;
        eoc = 1'b1; channel = 5'd24; tick; eoc = 1'b0;
        tick;
        repeat (63) tick;
        n_tests++;
        if ({timeout0, busy0} !== 2'b01) begin
            n_fail++; $display("FAIL t4_before: got to=%b busy=%b want to=0 busy=1", timeout0, busy0);
        end
        tick;
        n_tests++;
        if ({timeout0, busy0, timeout2, busy2} !== 4'b1010) begin
            n_fail++; $display("FAIL t4_timeout: got to0=%b b0=%b to2=%b b2=%b want 1010",
                timeout0, busy0, timeout2, busy2);
        end
        v2 = nval2;
        do_read(5'd24, 12'd200);
        do_read(5'd24, 12'd200);
        do_read(5'd24, 12'd200);
        do_read(5'd24, 12'd204);
        n_tests++;
        if ({nval2 - v2, if2.sample_o, if2.sample_ch_o, if0.sample_o, timeout0}
            !== {32'd1, 12'd201, 4'd2, 12'd204, 1'b1}) begin
            n_fail++; $display("FAIL t4_recover: got n=%0d s2=%0d ch=%0d s0=%0d to=%b want 1 201 2 204 1",
                nval2 - v2, if2.sample_o, if2.sample_ch_o, if0.sample_o, timeout0);
        end
    endtask

    task automatic test_overrun_and_reset;
        int d0, v0;
        reset_dut;
        d0 = nden0;
        eoc = 1'b1; channel = 5'd25; tick; eoc = 1'b0;
        tick;
        eoc = 1'b1; channel = 5'd22; tick; eoc = 1'b0;
        n_tests++;
        if ({overrun0, busy0, if0.den_o} !== 3'b110) begin
            n_fail++; $display("FAIL t5_overrun: got ov=%b busy=%b den=%b want 110", overrun0, busy0, if0.den_o);
        end
        drdy = 1'b1; do_data = 16'h3210; tick; drdy = 1'b0; do_data = '0;
        tick;
        n_tests++;
        if ({if0.sample_valid_o, if0.sample_o, if0.sample_ch_o} !== {1'b1, 12'h321, 4'd3}) begin
            n_fail++; $display("FAIL t5_first_read: got v=%b s=%h ch=%0d want v=1 s=321 ch=3",
                if0.sample_valid_o, if0.sample_o, if0.sample_ch_o);
        end
        tick; tick;
        n_tests++;
        if ({busy0, overrun0, nden0 - d0} !== {1'b0, 1'b1, 32'd1}) begin
            n_fail++; $display("FAIL t5_after: got busy=%b ov=%b dens=%0d want 0 1 1", busy0, overrun0, nden0 - d0);
        end
        // Reset while a read is outstanding.
        eoc = 1'b1; channel = 5'd22; tick; eoc = 1'b0;
        tick;
        rst = 1'b1; tick; rst = 1'b0;
        n_tests++;
        if ({if0.den_o, if0.daddr_o, if0.sample_o, if0.sample_ch_o, if0.sample_valid_o,
             busy0, timeout0, overrun0} !== 32'h0) begin
            n_fail++; $display("FAIL t5_reset_wait: got den=%b addr=%h smp=%h busy=%b ov=%b want all 0",
                if0.den_o, if0.daddr_o, if0.sample_o, busy0, overrun0);
        end
        v0 = nval0;
        drdy = 1'b1; do_data = 16'hFFF0; tick; drdy = 1'b0; do_data = '0;
        tick; tick;
        n_tests++;
        if ({nval0 - v0, busy0, if0.sample_o} !== {32'd0, 1'b0, 12'h000}) begin
            n_fail++; $display("FAIL t5_late_drdy: got n=%0d busy=%b s=%h want 0 0 000",
                nval0 - v0, busy0, if0.sample_o);
        end
    endtask

`ifdef XADC_SAMPLER_THRESH_EN
    task automatic test_thresh;
        reset_dut;
        do_read(5'd24, 12'h900);
        n_tests++;
        if (alarm0 !== 4'b0100) begin n_fail++; $display("FAIL t6_alarm: got %b want 0100", alarm0); end
        do_read(5'd24, 12'h100);
        do_read(5'd23, 12'h800);
        do_read(5'd22, 12'h7FF);
        n_tests++;
        if ({alarm0, alarm2} !== 8'b0100_0000) begin
            n_fail++; $display("FAIL t6_alarm_hold: got %b/%b want 0100/0000", alarm0, alarm2);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single_read;
        test_average;
        test_out_of_range;
        test_timeout;
        test_overrun_and_reset;
`ifdef XADC_SAMPLER_THRESH_EN
        test_thresh;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
